// File: rtl/range_table_om.sv
// -----------------------------------------------------------------------------
// range_table_om
//
// Small fully-associative table of address ranges {first, last, big, valid}.
// Entries are written round-robin at a write cursor, so the oldest slot is the
// one replaced once the table is full. A lookup reports, one cycle later,
// whether the address falls in any valid range, the lowest matching index, and
// whether it equals the start of a valid non-big range. Entries can be freed
// by start address. Every write, free and lookup in a cycle sees the table
// contents from before that cycle's updates.
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset, overrides everything
//   clear_i          synchronous flush of all entries and the cursor
//   wr_valid_i       store {wr_first_i, wr_last_i, wr_big_i} at the cursor
//   free_valid_i     invalidate lowest valid entry whose first == free_addr_i
//   req_valid_i      lookup of req_addr_i
//   rsp_*_o          registered lookup result, zero when rsp_valid_o is low
//   free_hit_o       previous-cycle free found an entry
//   overwrite_o      previous-cycle write replaced a valid entry
//   last_*_o         contents of the most recently written slot
//   count_o          number of valid entries; full_o / empty_o derived flags
// -----------------------------------------------------------------------------
module range_table_om #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_first_i,
    input  logic [ADDR_W-1:0] wr_last_i,
    input  logic              wr_big_i,
    input  logic              free_valid_i,
    input  logic [ADDR_W-1:0] free_addr_i,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    output logic              rsp_in_range_o,
    output logic              rsp_is_first_o,
    output logic [IDX_W-1:0]  rsp_idx_o,
    output logic              free_hit_o,
    output logic              overwrite_o,
    output logic [ADDR_W-1:0] last_first_o,
    output logic [ADDR_W-1:0] last_last_o,
    output logic              last_valid_o,
    output logic [IDX_W:0]    count_o,
    output logic              full_o,
    output logic              empty_o
);

    // Population count of the valid vector.
    function automatic logic [IDX_W:0] popcount(input logic [DEPTH-1:0] vec);
        logic [IDX_W:0] acc;
        acc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            acc = acc + {{IDX_W{1'b0}}, vec[i]};
        end
        return acc;
    endfunction

    // Table storage and cursor
    logic [ADDR_W-1:0] first_r [DEPTH];
    logic [ADDR_W-1:0] last_r  [DEPTH];
    logic [DEPTH-1:0]  big_r;
    logic [DEPTH-1:0]  valid_r;
    logic [IDX_W-1:0]  cursor_r;

    // Registered outputs
    logic              rsp_valid_r;
    logic              rsp_in_range_r;
    logic              rsp_is_first_r;
    logic [IDX_W-1:0]  rsp_idx_r;
    logic              free_hit_r;
    logic              overwrite_r;
    logic [IDX_W:0]    count_r;
    logic              full_r;
    logic              empty_r;

    // Combinational helpers
    logic              free_found_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic [DEPTH-1:0]  in_vec_s;
    logic [DEPTH-1:0]  first_vec_s;
    logic              in_any_s;
    logic              first_any_s;
    logic [IDX_W-1:0]  in_idx_s;
    logic [DEPTH-1:0]  valid_nxt_s;
    logic [IDX_W:0]    count_nxt_s;
    logic [IDX_W-1:0]  last_idx_s;

    // Free search: lowest valid index whose first matches the free address.
    // Scanning downward lets the lowest match be the last one assigned.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_r[i] && (first_r[i] == free_addr_i)) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Lookup match vectors; an entry with first > last can never satisfy both bounds.
    always_comb begin
        in_vec_s    = '0;
        first_vec_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            in_vec_s[i]    = valid_r[i] && (first_r[i] <= req_addr_i) && (req_addr_i <= last_r[i]);
            first_vec_s[i] = valid_r[i] && !big_r[i] && (first_r[i] == req_addr_i);
        end
        in_any_s    = |in_vec_s;
        first_any_s = |first_vec_s;
    end

    // Lowest in-range index priority encoder (0 when nothing matches).
    always_comb begin
        in_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (in_vec_s[i]) begin
                in_idx_s = IDX_W'(i);
            end else begin
                in_idx_s = in_idx_s;
            end
        end
    end

    // Next valid vector: clear dominates; write is applied after free so a
    // write to the slot being freed leaves it valid with the new data.
    always_comb begin
        valid_nxt_s = valid_r;
        if (clear_i) begin
            valid_nxt_s = '0;
        end else begin
            if (free_valid_i && free_found_s) begin
                valid_nxt_s[free_idx_s] = 1'b0;
            end else begin
                valid_nxt_s = valid_nxt_s;
            end
            if (wr_valid_i) begin
                valid_nxt_s[cursor_r] = 1'b1;
            end else begin
                valid_nxt_s = valid_nxt_s;
            end
        end
        count_nxt_s = popcount(valid_nxt_s);
    end

    // Table contents and cursor.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                first_r[i] <= '0;
                last_r[i]  <= '0;
            end
            big_r    <= '0;
            valid_r  <= '0;
            cursor_r <= '0;
        end else begin
            valid_r <= valid_nxt_s;
            if (clear_i) begin
                cursor_r <= '0;
            end else if (wr_valid_i) begin
                first_r[cursor_r] <= wr_first_i;
                last_r[cursor_r]  <= wr_last_i;
                big_r[cursor_r]   <= wr_big_i;
                cursor_r          <= cursor_r + IDX_W'(1);
            end
        end
    end

    // Status outputs: free/overwrite pulses and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_hit_r  <= 1'b0;
            overwrite_r <= 1'b0;
            count_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
        end else begin
            if (clear_i) begin
                free_hit_r  <= 1'b0;
                overwrite_r <= 1'b0;
            end else begin
                free_hit_r  <= free_valid_i && free_found_s;
                overwrite_r <= wr_valid_i && valid_r[cursor_r];
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == (IDX_W + 1)'(DEPTH));
            empty_r <= (count_nxt_s == '0);
        end
    end

    // Lookup response; computed on pre-update contents, even during a clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_r    <= 1'b0;
            rsp_in_range_r <= 1'b0;
            rsp_is_first_r <= 1'b0;
            rsp_idx_r      <= '0;
        end else begin
            rsp_valid_r    <= req_valid_i;
            rsp_in_range_r <= req_valid_i && in_any_s;
            rsp_is_first_r <= req_valid_i && first_any_s;
            rsp_idx_r      <= req_valid_i ? in_idx_s : '0;
        end
    end

    // Most recently written slot is the one just behind the cursor.
    always_comb begin
        last_idx_s = cursor_r - IDX_W'(1);
    end

    assign rsp_valid_o    = rsp_valid_r;
    assign rsp_in_range_o = rsp_in_range_r;
    assign rsp_is_first_o = rsp_is_first_r;
    assign rsp_idx_o      = rsp_idx_r;
    assign free_hit_o     = free_hit_r;
    assign overwrite_o    = overwrite_r;
    assign count_o        = count_r;
    assign full_o         = full_r;
    assign empty_o        = empty_r;
    assign last_first_o   = first_r[last_idx_s];
    assign last_last_o    = last_r[last_idx_s];
    assign last_valid_o   = valid_r[last_idx_s];

endmodule
